// File: rtl/mem_pkg.sv
// Shared encodings for the byte-lane data memory:
// RV32I load/store funct3 values, the init FSM states and request checks.
package mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {INIT, RUN} state_e;

   function automatic logic req_fault(
      input logic        i_we,
      input logic [2:0]  i_f3,
      input logic [31:0] i_a,
      input int unsigned i_depth
   );
      logic bad;
      case (i_f3)
         F3_LB:   bad = 1'b0;
         F3_LH:   bad = i_a[0];
         F3_LW:   bad = (i_a[1:0] != 2'b00);
         F3_LBU:  bad = i_we;
         F3_LHU:  bad = i_we | i_a[0];
         default: bad = 1'b1;
      endcase
      return bad | ({2'b00, i_a[31:2]} >= i_depth);
   endfunction

   // Store lanes for a legal store; SW always covers the whole word.
   function automatic logic [3:0] lane_mask(
      input logic [2:0] i_f3,
      input logic [1:0] i_off
   );
      case (i_f3[1:0])
         2'b00:   return 4'b0001 << i_off;
         2'b01:   return 4'b0011 << i_off;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bytelane_load_ext.sv
// Load aligner: picks the addressed byte/halfword out of a word
// and sign- or zero-extends it according to funct3.
module load_ext
   import mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_f3,
   output logic [31:0] o_data
);

   logic [31:0] w_sh;

   assign w_sh = i_word >> {i_off, 3'b000};

   always_comb begin
      o_data = '0;
      unique case (1'b1)
         (i_f3 == F3_LB):  o_data = {{24{w_sh[7]}}, w_sh[7:0]};
         (i_f3 == F3_LH):  o_data = {{16{w_sh[15]}}, w_sh[15:0]};
         (i_f3 == F3_LW):  o_data = w_sh;
         (i_f3 == F3_LBU): o_data = {24'h0, w_sh[7:0]};
         (i_f3 == F3_LHU): o_data = {16'h0, w_sh[15:0]};
         default:          o_data = '0;
      endcase
   end

endmodule

// File: rtl/dmem_bytelane.sv
// Dual-port byte-lane data memory with RV32I load/store decode,
// write-first forwarding across ports and a zero-fill init sweep.
module dmem_bytelane
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int INIT_CLEAR  = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ready,
   input  logic        req1,
   input  logic        we1,
   input  logic [2:0]  f31,
   input  logic [31:0] a1,
   input  logic [31:0] wd1,
   output logic [31:0] rd1,
   output logic        rvalid1,
   output logic        fault1,
   input  logic        req2,
   input  logic        we2,
   input  logic [2:0]  f32,
   input  logic [31:0] a2,
   input  logic [31:0] wd2,
   output logic [31:0] rd2,
   output logic        rvalid2,
   output logic        fault2
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);
   localparam state_e RST_ST = state_e'((INIT_CLEAR != 0) ? INIT : RUN);

   state_e        r_state, w_nst;
   logic [AW-1:0] r_cnt, w_ncnt;

   logic [7:0]    r_mem [DEPTH_WORDS][4];

   logic          w_req [2];
   logic          w_we  [2];
   logic [2:0]    w_f3  [2];
   logic [31:0]   w_a   [2];
   logic [31:0]   w_wd  [2];
   logic [AW-1:0] w_idx [2];
   logic          w_acc [2];
   logic          w_flt [2];
   logic [3:0]    w_msk [2];
   logic [31:0]   w_wsh [2];
   logic [31:0]   w_rw  [2];
   logic [31:0]   w_ld  [2];

   logic [1:0]    r_rv, r_flt;
   logic [31:0]   r_rd [2];

   assign w_req[0] = req1;
   assign w_we[0]  = we1;
   assign w_f3[0]  = f31;
   assign w_a[0]   = a1;
   assign w_wd[0]  = wd1;
   assign w_req[1] = req2;
   assign w_we[1]  = we2;
   assign w_f3[1]  = f32;
   assign w_a[1]   = a2;
   assign w_wd[1]  = wd2;

   // Gate with rst so ready drops the instant reset asserts.
   assign ready = rst & (r_state == RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RST_ST;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nst;
         r_cnt   <= w_ncnt;
      end
   end

   always_comb begin
      w_nst  = r_state;
      w_ncnt = r_cnt;
      unique case (r_state)
         INIT: begin
            w_ncnt = r_cnt + 1'b1;
            if (r_cnt == LAST) begin
               w_nst  = RUN;
               w_ncnt = '0;
            end
         end
         RUN: w_nst = RUN;
         default: w_nst = RST_ST;
      endcase
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_idx[p] = w_a[p][AW+1:2];
         w_acc[p] = w_req[p] & ready;
         w_flt[p] = req_fault(w_we[p], w_f3[p], w_a[p],
                              DEPTH_WORDS);
         w_msk[p] = (w_acc[p] & ~w_flt[p] & w_we[p])
                  ? lane_mask(w_f3[p], w_a[p][1:0]) : 4'b0000;
         w_wsh[p] = w_wd[p] << {w_a[p][1:0], 3'b000};
      end
   end

   // Write-first: a load sees bytes the other port stores this cycle.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rw[p] = '0;
         for (int l = 0; l < 4; l++) begin
            w_rw[p][8*l +: 8] = r_mem[w_idx[p]][l];
            if (w_msk[1-p][l] && (w_idx[1-p] == w_idx[p]))
               w_rw[p][8*l +: 8] = w_wsh[1-p][8*l +: 8];
         end
      end
   end

   // Port 2 is written last so it wins overlapping lanes.
   always_ff @(posedge clk) begin
      if (r_state == INIT && rst) begin
         for (int l = 0; l < 4; l++)
            r_mem[r_cnt][l] <= 8'h00;
      end else begin
         for (int p = 0; p < 2; p++)
            for (int l = 0; l < 4; l++)
               if (w_msk[p][l])
                  r_mem[w_idx[p]][l] <= w_wsh[p][8*l +: 8];
      end
   end

   load_ext u_ext1 (
      .i_word (w_rw[0]),
      .i_off  (w_a[0][1:0]),
      .i_f3   (w_f3[0]),
      .o_data (w_ld[0])
   );

   load_ext u_ext2 (
      .i_word (w_rw[1]),
      .i_off  (w_a[1][1:0]),
      .i_f3   (w_f3[1]),
      .o_data (w_ld[1])
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rv    <= '0;
         r_flt   <= '0;
         r_rd[0] <= '0;
         r_rd[1] <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            r_rv[p]  <= w_acc[p] & ~w_flt[p] & ~w_we[p];
            r_flt[p] <= w_acc[p] & w_flt[p];
            r_rd[p]  <= (w_acc[p] & ~w_flt[p] & ~w_we[p])
                      ? w_ld[p] : 32'h0;
         end
      end
   end

   assign rvalid1 = r_rv[0];
   assign rvalid2 = r_rv[1];
   assign fault1  = r_flt[0];
   assign fault2  = r_flt[1];
   assign rd1     = r_rd[0];
   assign rd2     = r_rd[1];

endmodule

// File: doc/dmem_bytelane.md
DMEM_BYTELANE -- requirements
Module: dmem_bytelane

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words; power of two, 4..4096.
REQ-002 SHALL have parameter INIT_CLEAR, default 1, meaning 1 = zero-fill the array after reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port ready, output, 1, meaning the block accepts requests.
REQ-006 SHALL provide, for each port p in {1,2}:
- reqp, input, 1, request strobe.
- wep, input, 1, 1 = store, 0 = load.
- f3p, input, 3, RV32I funct3.
- ap, input, 32, byte address.
- wdp, input, 32, store data, right-aligned.
- rdp, output, 32, load data, extended.
- rvalidp, output, 1, load data valid.
- faultp, output, 1, request rejected.

Function
REQ-007 SHALL accept a request only when reqp=1 and ready=1; all other requests are ignored with no response.
REQ-008 SHALL word-index with ap[31:2] and byte-lane with ap[1:0].
REQ-009 SHALL decode stores: f3 000 = SB (1 lane), 001 = SH (2 lanes), 010 = SW (4 lanes); store data is shifted to the addressed lanes.
REQ-010 SHALL decode loads: 000 LB, 001 LH, 010 LW (sign-extend for LB/LH); 100 LBU, 101 LHU (zero-extend).
REQ-011 SHALL return load data one cycle after acceptance, with rvalidp=1 for exactly that one cycle; rdp=0 when rvalidp=0.
REQ-012 SHALL raise faultp for one cycle (one cycle after acceptance) on any of these, with no write and rvalidp=0:
- halfword access with ap[0]=1;
- word access with ap[1:0]!=0;
- ap[31:2] >= DEPTH_WORDS;
- undefined funct3 (011, 110, 111, or 1xx with wep=1).
REQ-013 SHALL handle both ports storing to the same word in one cycle as follows: lanes merge, and port 2 data wins on overlapping lanes.
REQ-014 SHALL make a load on one port and a store on the other to the same word in one cycle return the newly written bytes for written lanes and the old bytes for the others (write-first).
REQ-015 SHALL, when INIT_CLEAR=1, run a state machine with states INIT and RUN:
- After reset release it enters INIT.
- In INIT it writes zero to word 0..DEPTH_WORDS-1, one word per cycle.
- It moves to RUN the cycle after the last word is written.
- ready=1 only in RUN.
REQ-016 SHALL, when INIT_CLEAR=0, enter RUN directly after reset with array contents undefined.
REQ-017 SHALL restart the INIT counter at word 0 if reset asserts mid-INIT.

Reset
REQ-018 SHALL, while rst=0, asynchronously force:
- ready=0, rvalid1=0, rvalid2=0, fault1=0, fault2=0, rd1=0, rd2=0;
- state=INIT (or RUN if INIT_CLEAR=0);
- init counter=0.
REQ-019 SHALL NOT reset array contents asynchronously; clearing is performed only by INIT.
REQ-020 SHALL drop a request in flight when reset is asserted: no rvalid or fault follows.

Structure
REQ-021 SHALL take the funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum {INIT, RUN} from shared package mem_pkg.
REQ-022 SHALL instantiate one sub-module, load_ext, which is combinational: it takes the raw word, ap[1:0] and f3, and produces the extended load result; it is instantiated once per port.
REQ-023 SHALL store the array as DEPTH_WORDS x 4 byte lanes, each lane with its own write enable.

Verification
REQ-024 SHALL cover init: DEPTH_WORDS=64, INIT_CLEAR=1, release rst -> ready rises exactly 64 cycles later; LW at 0xFC returns 0x00000000.
REQ-025 SHALL cover byte store and extended loads: SB wd=0x000000F0 at a=0x05, then LB a=0x05 -> 0xFFFFFFF0 with rvalid one cycle later; LBU a=0x05 -> 0x000000F0; LW a=0x04 -> 0x0000F000.
REQ-026 SHALL cover the dual-store collision: port1 SW 0x11223344 and port2 SH 0xAABB at a=0x08 in the same cycle -> LW 0x08 = 0x1122AABB.
REQ-027 SHALL cover faults: LW a=0x02 -> fault1=1 for one cycle, rvalid1=0; SW a=0x100 with DEPTH=64 -> fault, word 0 unchanged.
REQ-028 SHALL cover write-first forwarding: port1 LW a=0x10 (old 0x0) with port2 SB 0x7F at a=0x11 in the same cycle -> rd1=0x00007F00.
REQ-029 SHALL cover reset mid-INIT: assert rst at init word 20 -> ready stays 0, and after release INIT restarts at word 0 and takes the full 64 cycles.
